// File: rtl/banked_ram_pkg.sv
// Shared definitions for the Hack data-memory blocks: default sizes,
// the clear/idle state encoding and a constant-safe ceil(log2) helper.
package hack_mem_pkg;

  localparam int HACK_DATA_W = 16;
  localparam int HACK_ADDR_W = 14;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/banked_ram_bank.sv
// ram_bank: single-port synchronous bank, read-before-write, no reset so it
// maps onto block RAM.
module ram_bank
  import hack_mem_pkg::*;
#(
  parameter int DATA_W = HACK_DATA_W,
  parameter int ROW_W  = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_reg [2**ROW_W];

  always_ff @(posedge clk) begin
    if (we) mem_reg[row] <= din;
    dout <= mem_reg[row];
  end

endmodule

// File: rtl/banked_ram.sv
// banked_ram: 2^ADDR_W x DATA_W memory split into BANKS banks, zero-cleared
// after reset, registered read with valid strobe. Optional macro
// BANKED_RAM_BYPASS_EN makes a same-cycle load+read return the new data.
module banked_ram
  import hack_mem_pkg::*;
#(
  parameter int DATA_W = HACK_DATA_W,
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int BANKS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              rd_en,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
);

  localparam int BSEL_W     = clog2(BANKS);
  localparam int ROW_W      = ADDR_W - BSEL_W;
  localparam int BANK_DEPTH = 2 ** ROW_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BANK_DEPTH - 1);

  state_t            state_reg, state_next;
  logic [ROW_W-1:0]  clr_row_reg, clr_row_next;

  logic [BSEL_W-1:0] bank_sel;
  logic [ROW_W-1:0]  addr_row;
  logic [ROW_W-1:0]  bank_row;
  logic [DATA_W-1:0] bank_din;
  logic [BANKS-1:0]  bank_we;
  logic [DATA_W-1:0] bank_dout [BANKS];

  logic              rd_fire, wr_fire;
  logic              valid_reg;
  logic [BSEL_W-1:0] rsel_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] rdata;

  assign bank_sel = addr[ADDR_W-1 -: BSEL_W];
  assign addr_row = addr[ROW_W-1:0];
  assign busy     = (state_reg == CLEAR);
  assign rd_fire  = rd_en && !busy;
  assign wr_fire  = load && !busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_row_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_row_reg <= clr_row_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_row_next = clr_row_reg;
    case (state_reg)
      CLEAR: begin
        clr_row_next = clr_row_reg + 1'b1;
        if (clr_row_reg == LAST_ROW) state_next = IDLE;
      end
      IDLE:    state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  // The clear engine owns every bank's port while busy; afterwards the
  // single shared address drives both the read and the (decoded) write.
  assign bank_row = busy ? clr_row_reg : addr_row;
  assign bank_din = busy ? '0 : in;

  generate
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
      assign bank_we[gi] = busy || (wr_fire && (bank_sel == BSEL_W'(gi)));

      ram_bank #(
        .DATA_W (DATA_W),
        .ROW_W  (ROW_W)
      ) u_bank (
        .clk  (clk),
        .we   (bank_we[gi]),
        .row  (bank_row),
        .din  (bank_din),
        .dout (bank_dout[gi])
      );
    end
  endgenerate

`ifdef BANKED_RAM_BYPASS_EN
  logic              byp_reg;
  logic [DATA_W-1:0] byp_data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_reg      <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      byp_reg <= rd_fire && wr_fire;
      if (rd_fire && wr_fire) byp_data_reg <= in;
    end
  end

  always_comb begin
    rdata = bank_dout[rsel_reg];
    if (byp_reg) rdata = byp_data_reg;
  end
`else
  always_comb begin
    rdata = bank_dout[rsel_reg];
  end
`endif

  // hold_reg keeps the last delivered word so out stays stable between reads
  // while the bank outputs keep tracking addr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      rsel_reg  <= '0;
      hold_reg  <= '0;
    end else begin
      valid_reg <= rd_fire;
      if (rd_fire) rsel_reg <= bank_sel;
      if (valid_reg) hold_reg <= rdata;
    end
  end

  assign out       = valid_reg ? rdata : hold_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_banked_ram.sv
// Scoreboard bench for banked_ram (ADDR_W=6, BANKS=4, 16 rows per bank):
// reads push expectations, a negedge monitor pops them on out_valid.
module tb_banked_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        load, rd_en;
  logic [15:0] in_d, out_d;
  logic [5:0]  addr;
  logic        out_valid, busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [5:0]  tag_q[$];

  always #5 clk = ~clk;

  banked_ram #(
    .DATA_W (16),
    .ADDR_W (6),
    .BANKS  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_d),
    .addr      (addr),
    .load      (load),
    .rd_en     (rd_en),
    .out       (out_d),
    .out_valid (out_valid),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every valid strobe must match the oldest outstanding read.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%h required=no_valid", out_d);
      end else begin
        logic [15:0] e;
        logic [5:0]  a;
        e = exp_q.pop_front();
        a = tag_q.pop_front();
        $display("read addr=%h out=%h expected=%h", a, out_d, e);
        check("read_data", out_d, e);
      end
    end
  end

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    addr = a; in_d = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] e);
    addr = a; rd_en = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(a);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Counts negedges with busy high, starting at the release negedge.
  task automatic wait_idle(input string name, input bit poke);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      if (poke) begin
        load = 1'b1; rd_en = 1'b1; addr = 6'h3F; in_d = 16'h5555;
      end
      n++;
      @(negedge clk);
    end
    load = 1'b0; rd_en = 1'b0;
    $display("clear %s busy_cycles=%0d", name, n);
    check(name, 16'(n), 16'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; load = 1'b0; rd_en = 1'b0; addr = '0; in_d = '0;
    repeat (2) @(negedge clk);
    check("reset_out", out_d, 16'h0000);
    check("reset_valid", {15'b0, out_valid}, 16'h0000);
    check("reset_busy", {15'b0, busy}, 16'h0001);

    reset = 1'b0;
    wait_idle("busy_len_initial", 1'b0);

    for (int i = 0; i < 64; i++) rd(6'(i), 16'h0000);

    wr(6'h05, 16'h1111);
    wr(6'h15, 16'h2222);
    wr(6'h25, 16'h3333);
    wr(6'h35, 16'h4444);
    rd(6'h05, 16'h1111);
    rd(6'h15, 16'h2222);
    rd(6'h25, 16'h3333);
    rd(6'h35, 16'h4444);

    rd(6'h15, 16'h2222);
    addr = 6'h25;
    @(negedge clk);
    check("hold_valid_1", {15'b0, out_valid}, 16'h0000);
    check("hold_out_1", out_d, 16'h2222);
    addr = 6'h35;
    @(negedge clk);
    check("hold_valid_2", {15'b0, out_valid}, 16'h0000);
    check("hold_out_2", out_d, 16'h2222);

    // Same-address load and read in one edge.
    addr = 6'h05; in_d = 16'hBEEF; load = 1'b1; rd_en = 1'b1;
`ifdef BANKED_RAM_BYPASS_EN
    exp_q.push_back(16'hBEEF);
`else
    exp_q.push_back(16'h1111);
`endif
    tag_q.push_back(6'h05);
    @(negedge clk);
    load = 1'b0; rd_en = 1'b0;
    $display("write addr=05 data=beef (with read)");
    rd(6'h05, 16'hBEEF);
    rd(6'h25, 16'h3333);
    @(negedge clk);

    // Reset mid-cycle while out holds data, then again 5 cycles into clear.
    #2 reset = 1'b1;
    #1;
    check("async_rst_out", out_d, 16'h0000);
    check("async_rst_valid", {15'b0, out_valid}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midclear_busy", {15'b0, busy}, 16'h0001);
    #2 reset = 1'b1;
    #1;
    check("midclear_out", out_d, 16'h0000);
    check("midclear_valid", {15'b0, out_valid}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    wait_idle("busy_len_midclear", 1'b0);

    // Data written before reset must be gone; loads while busy are dropped.
    wr(6'h3F, 16'hAAAA);
    rd(6'h3F, 16'hAAAA);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_idle("busy_len_after_data", 1'b1);
    rd(6'h3F, 16'h0000);
    rd(6'h05, 16'h0000);
    rd(6'h15, 16'h0000);
    wr(6'h3F, 16'h0F0F);
    rd(6'h3F, 16'h0F0F);
    rd(6'h3E, 16'h0000);
    repeat (3) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
